latch_capture_rx: RTL and testbench
===================================

// Module: latch_capture_rx
// PURPOSE
//  Reader side of the level-sensitive latch interface. An external transparent latch
//  drives lat_d and is open while lat_en is high; the data is frozen when lat_en falls.
//  This block synchronises lat_en into the clk domain, rejects short enable glitches and
//  captures lat_d on each qualified closing edge. It buffers the words in a small FIFO
//  and delivers them over a valid/ready stream into the edge-triggered (flop) fabric.
// PARAMETERS
//  DATA_W      8  width of lat_d / out_data
//  SYNC_STAGES 2  flops in the lat_en synchroniser (>=2)
//  MIN_OPEN    2  minimum synced-high cycles of lat_en for a close to count (>=1)
//  FIFO_DEPTH  4  capture FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous, active-low reset
//  lat_en     in   1                  latch enable, asynchronous level (high = open)
//  lat_d      in   DATA_W             latch output; source holds it stable from lat_en fall
//                                     for >= SYNC_STAGES+3 clk cycles
//  out_valid  out  1                  FIFO head word available
//  out_ready  in   1                  consumer accepts head word when out_valid=1
//  out_data   out  DATA_W             FIFO head word (show-ahead)
//  overflow   out  1                  1-cycle pulse: capture dropped because FIFO full
//  glitch     out  1                  1-cycle pulse: close rejected (open < MIN_OPEN)
//  fifo_count out  $clog2(FIFO_DEPTH)+1 current occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): sync chain=0, en_prev=0, FSM=IDLE, open_cnt=0,
//   FIFO empty; out_valid=0, out_data=0, overflow=0, glitch=0, fifo_count=0.
//  Sync: lat_en -> SYNC_STAGES flops -> en_s; en_prev <= en_s. rise=en_s&!en_prev,
//   fall=!en_s&en_prev. lat_d is not synchronised; its stability is the source contract.
//  FSM (state type in package):
//   IDLE   : rise -> OPEN, open_cnt<=1.
//   OPEN   : en_s=1 -> open_cnt<=sat_inc (saturates at MIN_OPEN);
//            fall & open_cnt>=MIN_OPEN -> CAPTURE; fall & open_cnt<MIN_OPEN -> IDLE, glitch=1.
//   CAPTURE: single cycle; push lat_d; if FIFO full and no pop this cycle -> drop, overflow=1;
//            next state IDLE. A rise seen in CAPTURE is still honoured: -> OPEN, open_cnt<=1.
//  Latency: first clk edge that samples lat_en=0 is edge 0; with FIFO empty, out_valid=1
//   after edge SYNC_STAGES+2 (sync, fall detect, CAPTURE push).
//  Stream: out_valid = !empty; pop on out_valid&out_ready; out_data stable while out_valid=1
//   and out_ready=0. Push and pop in the same cycle: count unchanged, and the push is accepted
//   even when the FIFO is full. Pointers wrap modulo FIFO_DEPTH; count uses an extra bit to
//   tell full from empty.
//  lat_en high at reset release: the sync chain sees a rise -> OPEN (capture is legitimate).
//  Reset mid-OPEN/CAPTURE: the word in flight and all FIFO contents are discarded.
//  overflow and glitch are never asserted in the same cycle.
// STRUCTURE
//  Package latch_capture_pkg: FSM state enum (IDLE, OPEN, CAPTURE), default param constants.
//  Sub-module latch_capture_fifo: sync show-ahead FIFO (DATA_W, FIFO_DEPTH) with push, pop,
//   full, empty and count. Synchroniser, edge detect and FSM live in the top module.
// TESTING
//  1 lat_d=8'hA5, lat_en high 6 cyc then low, out_ready=1 -> out_data=A5, out_valid high for
//    1 cycle at edge 4 after the fall.
//  2 lat_en high 1 synced cycle (MIN_OPEN=2) -> glitch pulse, no push, fifo_count stays 0.
//  3 out_ready=0; 5 captures 01..05 -> fifo_count=4, overflow on the 5th; drain -> 01,02,03,04.
//  4 FIFO full, 5th capture in the same cycle as a pop -> no overflow; data order 02..05.
//  5 rst_n low during OPEN with 2 words queued -> all outputs 0 immediately; after release,
//    lat_en still high -> next close captures normally.
//  6 back-to-back: lat_en re-rises during CAPTURE -> both words captured in order.

Source files
------------

// File: rtl/latch_capture_pkg.sv
// Shared types and default parameters for the latch capture reader.
package latch_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CAPTURE = 2'd2
    } lc_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_OPEN    = 2;
    localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/latch_capture_fifo.sv
// Synchronous show-ahead FIFO; head word visible combinationally, one-cycle push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module latch_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_dat,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [DATA_W-1:0]          o_head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    // Gate the head so the output reads zero while nothing is queued.
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/latch_capture_rx.sv
// Captures lat_d on each qualified lat_en close; first word valid SYNC_STAGES+2 edges after close.
// Valid/ready output from a show-ahead FIFO; a capture into a full FIFO with no pop is dropped.
module latch_capture_rx
    import latch_capture_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_OPEN    = DEF_MIN_OPEN,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          lat_en,
    input  logic [DATA_W-1:0]             lat_d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          overflow,
    output logic                          glitch,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CNT_W = $clog2(MIN_OPEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_en_prev;
    logic                   r_rise;
    logic                   r_fall;
    lc_state_t              r_state;
    logic [CNT_W-1:0]       r_open_cnt;
    logic                   r_glitch;
    logic                   r_overflow;

    logic                   w_en_s;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_drop;

    assign w_en_s    = r_sync[SYNC_STAGES-1];
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_capture = (r_state == CAPTURE);
    assign w_drop    = w_capture & w_full & ~w_pop;
    assign overflow  = r_overflow;
    assign glitch    = r_glitch;

    // Edges are registered, so the FSM works on a one-cycle-delayed view of
    // en_s whose level is r_en_prev; this gives the extra fall-detect stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_en_prev <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], lat_en};
            r_en_prev <= w_en_s;
            r_rise    <= w_en_s & ~r_en_prev;
            r_fall    <= ~w_en_s & r_en_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_open_cnt <= '0;
            r_glitch   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_glitch   <= 1'b0;
            r_overflow <= w_drop;
            case (r_state)
                IDLE: begin
                    if (r_rise) begin
                        r_state    <= OPEN;
                        r_open_cnt <= CNT_W'(1);
                    end
                end
                OPEN: begin
                    if (r_fall) begin
                        if (r_open_cnt >= CNT_W'(MIN_OPEN)) begin
                            r_state <= CAPTURE;
                        end else begin
                            r_state  <= IDLE;
                            r_glitch <= 1'b1;
                        end
                    end else if (r_en_prev && (r_open_cnt < CNT_W'(MIN_OPEN))) begin
                        r_open_cnt <= r_open_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    // A fresh open arriving during the capture cycle is not lost.
                    if (r_rise) begin
                        r_state    <= OPEN;
                        r_open_cnt <= CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    latch_capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_capture),
        .i_push_dat (lat_d),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (fifo_count),
        .o_head_dat (out_data)
    );

endmodule

// File: tb/tb_latch_capture_rx.sv
// Directed bench for latch_capture_rx: latency, glitch reject, overflow, reset, back-to-back.
module tb_latch_capture_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       lat_en;
    logic [7:0] lat_d;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       overflow;
    logic       glitch;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    latch_capture_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lat_en     (lat_en),
        .lat_d      (lat_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
        .glitch     (glitch),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Open for open_cyc cycles, close, and wait through the capture edge.
    task automatic capture_word(input logic [7:0] d, input int open_cyc, output logic ovf);
        lat_d  = d;
        lat_en = 1'b1;
        tick(open_cyc);
        lat_en = 1'b0;
        tick(5);
        ovf = overflow;
    endtask

    task automatic drain_check(input string tag, input logic [7:0] first, input int n);
        logic [7:0] exp_d;
        out_ready = 1'b1;
        exp_d = first;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 16'(out_valid), 16'd1);
            check({tag, "_data"}, 16'(out_data), 16'(exp_d));
            exp_d = exp_d + 8'd1;
            tick(1);
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        logic ovf;
        int   g_cnt;
        int   o_cnt;

        rst_n = 1'b0; lat_en = 1'b0; lat_d = 8'h00; out_ready = 1'b0;
        tick(2);
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_data",  16'(out_data),  16'd0);
        check("rst_count", 16'(fifo_count), 16'd0);
        check("rst_ovf",   16'(overflow),  16'd0);
        check("rst_glitch",16'(glitch),    16'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: basic capture, valid appears after edge 4 and pops at edge 5
        out_ready = 1'b1;
        lat_d  = 8'hA5;
        lat_en = 1'b1;
        tick(6);
        lat_en = 1'b0;
        tick(4);
        check("t1_valid_e3", 16'(out_valid), 16'd0);
        tick(1);
        check("t1_valid_e4", 16'(out_valid), 16'd1);
        check("t1_data_e4",  16'(out_data),  16'hA5);
        tick(1);
        check("t1_valid_e5", 16'(out_valid), 16'd0);
        out_ready = 1'b0;
        tick(2);

        // 2: one synced cycle of enable is a glitch
        g_cnt = 0; o_cnt = 0;
        lat_d  = 8'h77;
        lat_en = 1'b1;
        tick(1);
        lat_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            g_cnt += int'(glitch);
            o_cnt += int'(out_valid);
        end
        check("t2_glitch_pulses", 16'(g_cnt), 16'd1);
        check("t2_no_valid",      16'(o_cnt), 16'd0);
        check("t2_count",         16'(fifo_count), 16'd0);

        // 3: overflow on fifth capture with consumer stalled
        for (int i = 1; i <= 5; i++) begin
            capture_word(8'(i), 4, ovf);
            if (i == 4) check("t3_ovf_4th", 16'(ovf), 16'd0);
        end
        check("t3_ovf_5th", 16'(ovf), 16'd1);
        check("t3_count",   16'(fifo_count), 16'd4);
        tick(1);
        check("t3_ovf_pulse", 16'(overflow), 16'd0);
        drain_check("t3", 8'h01, 4);
        tick(1);

        // 4: full FIFO, fifth push coincides with a pop
        for (int i = 1; i <= 4; i++) capture_word(8'(i), 4, ovf);
        check("t4_count_full", 16'(fifo_count), 16'd4);
        lat_d  = 8'h05;
        lat_en = 1'b1;
        tick(4);
        lat_en = 1'b0;
        tick(4);
        out_ready = 1'b1;
        check("t4_head_popped", 16'(out_data), 16'h01);
        tick(1);
        out_ready = 1'b0;
        tick(1);
        check("t4_no_ovf", 16'(overflow),   16'd0);
        check("t4_count",  16'(fifo_count), 16'd4);
        drain_check("t4", 8'h02, 4);
        tick(1);

        // 5: reset during OPEN with two words queued
        capture_word(8'h11, 4, ovf);
        capture_word(8'h22, 4, ovf);
        check("t5_count_pre", 16'(fifo_count), 16'd2);
        lat_d  = 8'h33;
        lat_en = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 16'(out_valid),  16'd0);
        check("t5_rst_count", 16'(fifo_count), 16'd0);
        check("t5_rst_data",  16'(out_data),   16'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        lat_en = 1'b0;
        tick(5);
        check("t5_count_post", 16'(fifo_count), 16'd1);
        check("t5_data_post",  16'(out_data),   16'h33);
        drain_check("t5", 8'h33, 1);
        tick(1);

        // 6: enable re-rises during the capture cycle
        g_cnt = 0;
        lat_d  = 8'h5A;
        lat_en = 1'b1;
        tick(4);
        lat_en = 1'b0;
        tick(1);
        lat_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            g_cnt += int'(glitch);
        end
        lat_d = 8'hC3;
        tick(3);
        lat_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            g_cnt += int'(glitch);
        end
        check("t6_no_glitch", 16'(g_cnt),      16'd0);
        check("t6_count",     16'(fifo_count), 16'd2);
        out_ready = 1'b1;
        check("t6_first",  16'(out_data), 16'h5A);
        tick(1);
        check("t6_second", 16'(out_data), 16'hC3);
        tick(1);
        out_ready = 1'b0;
        check("t6_empty",  16'(out_valid), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
